nvram_autosave_ctrl: RTL and testbench

// Parametrised NVRAM/hiscore dump controller between the ioctl loader bus and a core's NVRAM port.
// It handles NVRAM download (restore) and upload (save) on a configurable ioctl index.
// It pauses the CPU for any access that competes with the core.
// It adds change-detecting autosave: on OSD open it checksums the NVRAM region and requests an

---
 rtl/nvram_autosave_ctrl.sv | 101 ++++++++++
 tb/tb_nvram_autosave_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nvram_autosave_ctrl.sv
// nvram_autosave_ctrl: NVRAM restore/save over ioctl with change-detecting autosave on OSD open
module nvram_autosave_ctrl #(
  parameter int DUMPWIDTH = 6,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2,
  parameter int CHKWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic                 ioctl_upload,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_index,
  output logic [7:0]           ioctl_din,
  output logic                 ioctl_upload_req,
  input  logic                 OSD_STATUS,
  input  logic                 autosave,
  input  logic                 paused,
  output logic [DUMPWIDTH-1:0] nvram_address,
  input  logic [7:0]           nvram_data_out,
  output logic                 pause_cpu
);
  typedef enum logic [2:0] {IDLE, WAIT_PAUSE, PAD, SCAN, FINISH, XFER} state_t;
  state_t state, state_n;
  logic osd_q, dl_q, base_pend, mode_base, bv, vld, tail;
  logic sel, dl, ul, xfer, osd_rise, dl_fall, unused;
  logic [7:0] cnt;
  logic [DUMPWIDTH-1:0] addr;
  logic [CHKWIDTH-1:0] acc, saved, fold;
  assign sel = ioctl_index == 8'(DUMPINDEX);
  assign dl = ioctl_download & sel;
  assign ul = ioctl_upload & sel;
  assign xfer = dl | ul;
  assign osd_rise = OSD_STATUS & ~osd_q;
  assign dl_fall = dl_q & ~dl;
  assign fold = {acc[CHKWIDTH-2:0], acc[CHKWIDTH-1]} + CHKWIDTH'(nvram_data_out);
  assign nvram_address = state == SCAN ? addr : state == XFER ? ioctl_addr[DUMPWIDTH-1:0] : '0;
  assign ioctl_din = state == XFER ? nvram_data_out : 8'h00;
  assign unused = &{1'b0, ioctl_wr, ioctl_addr[24:DUMPWIDTH]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = xfer ? XFER : ((osd_rise & autosave) | dl_fall | base_pend) ? WAIT_PAUSE : IDLE;
      WAIT_PAUSE: state_n = xfer ? XFER : !paused ? WAIT_PAUSE : PAUSEPAD == 0 ? SCAN : PAD;
      PAD:        state_n = xfer ? XFER : cnt == 8'd0 ? SCAN : PAD;
      SCAN:       state_n = xfer ? XFER : !paused ? WAIT_PAUSE : tail ? FINISH : SCAN;
      FINISH:     state_n = IDLE;
      XFER:       state_n = xfer ? XFER : IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osd_q <= 1'b0;
      dl_q <= 1'b0;
      base_pend <= 1'b0;
      mode_base <= 1'b0;
      bv <= 1'b0;
      vld <= 1'b0;
      tail <= 1'b0;
      cnt <= 8'd0;
      addr <= '0;
      acc <= '0;
      saved <= '0;
      pause_cpu <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      osd_q <= OSD_STATUS;
      dl_q <= dl;
      // a download that ends while in XFER is remembered so IDLE can re-baseline
      base_pend <= dl_fall | (base_pend & state != IDLE);
      pause_cpu <= state inside {WAIT_PAUSE, PAD, SCAN, XFER};
      ioctl_upload_req <= state == FINISH && !mode_base && bv && acc != saved;
      cnt <= state == PAD ? cnt - 8'd1 : 8'(PAUSEPAD - 1);
      if (state == IDLE) mode_base <= !(osd_rise & autosave);
      if (state == WAIT_PAUSE || state == PAD) begin
        addr <= '0;
        acc <= '0;
        vld <= 1'b0;
        tail <= 1'b0;
      end
      // read data lags the issued address by one cycle; tail is the final fold-only cycle
      if (state == SCAN) begin
        if (vld) acc <= fold;
        if (!tail) begin
          vld <= 1'b1;
          tail <= &addr;
          if (!(&addr)) addr <= addr + 1'b1;
        end
      end
      if (state == FINISH) begin
        saved <= acc;
        bv <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nvram_autosave_ctrl.sv
// tb_nvram_autosave_ctrl: randomized checks against a checksum/baseline reference model
module tb_nvram_autosave_ctrl;
  logic clk = 0, reset = 1;
  logic ioctl_download = 0, ioctl_upload = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_index = '0, ioctl_din, nvram_data_out = '0;
  logic ioctl_upload_req, OSD_STATUS = 0, autosave = 0, paused = 0, pause_cpu;
  logic [5:0] nvram_address;
  logic [7:0] mem [64];
  int checks = 0, errors = 0;
  bit ref_bv = 0;
  logic [15:0] ref_saved = '0;

  nvram_autosave_ctrl dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
    .ioctl_upload_req(ioctl_upload_req), .OSD_STATUS(OSD_STATUS), .autosave(autosave), .paused(paused),
    .nvram_address(nvram_address), .nvram_data_out(nvram_data_out), .pause_cpu(pause_cpu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    nvram_data_out <= mem[nvram_address];
    paused <= pause_cpu;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum();
    logic [15:0] s = '0;
    for (int i = 0; i < 64; i++) s = ((s << 1) | (s >> 15)) + 16'(mem[i]);
    return s;
  endfunction

  task automatic osd_cycle(input bit en);
    int n = 0, first = -1;
    logic [15:0] c = ref_sum();
    bit exp = 0;
    autosave = en;
    OSD_STATUS = 1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (ioctl_upload_req) begin
        n++;
        if (first < 0) first = i;
      end
    end
    OSD_STATUS = 0;
    repeat (3) @(negedge clk);
    if (en) begin
      if (!ref_bv) begin
        ref_saved = c;
        ref_bv = 1;
      end else if (c != ref_saved) begin
        ref_saved = c;
        exp = 1;
      end
    end
    chk("osd_req_count", n, exp);
    if (exp) chk("osd_req_latency", first >= 64 && first <= 80, 1);
  endtask

  task automatic quiet_window(input string tag);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n += ioctl_upload_req;
    end
    chk(tag, n, 0);
  endtask

  initial begin
    int a;
    bit found;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_pause", pause_cpu, 0);
    chk("rst_req", ioctl_upload_req, 0);
    chk("rst_addr", nvram_address, 0);
    chk("rst_din", ioctl_din, 0);

    osd_cycle(1);
    mem[3] = 8'h5A;
    osd_cycle(1);
    osd_cycle(1);

    ioctl_index = 4;
    ioctl_download = 1;
    for (int i = 0; i < 64; i++) begin
      ioctl_addr = 25'(i);
      ioctl_wr = 1;
      mem[i] = 8'($urandom);
      @(negedge clk);
      chk("dl_addr", nvram_address, i);
      if (i > 0) chk("dl_pause", pause_cpu, 1);
    end
    ioctl_download = 0;
    ioctl_wr = 0;
    ref_saved = ref_sum();
    ref_bv = 1;
    quiet_window("dl_baseline_no_req");
    osd_cycle(1);

    mem[9] = mem[9] ^ 8'h81;
    OSD_STATUS = 1;
    autosave = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = nvram_address == 6'd20;
    end
    chk("scan_reaches_20", found, 1);
    ioctl_upload = 1;
    a = $urandom_range(0, 63);
    ioctl_addr = 25'(a);
    @(negedge clk);
    chk("ul_xfer_addr", nvram_address, a);
    chk("ul_pause", pause_cpu, 1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 63);
      ioctl_addr = 25'(a);
      @(negedge clk);
      chk("ul_din", ioctl_din, mem[a]);
      chk("ul_req_low", ioctl_upload_req, 0);
    end
    ioctl_upload = 0;
    OSD_STATUS = 0;
    quiet_window("ul_abort_no_req");

    ioctl_index = 0;
    ioctl_download = 1;
    for (int i = 0; i < 20; i++) begin
      ioctl_addr = 25'($urandom_range(1, 63));
      @(negedge clk);
      chk("idx0_pause", pause_cpu, 0);
      chk("idx0_addr", nvram_address, 0);
    end
    ioctl_download = 0;
    quiet_window("idx0_no_req");
    chk("idx0_pause_end", pause_cpu, 0);
    ioctl_index = 4;

    OSD_STATUS = 1;
    autosave = 1;
    repeat (30) @(negedge clk);
    reset = 1;
    #1;
    chk("rst_mid_pause", pause_cpu, 0);
    chk("rst_mid_addr", nvram_address, 0);
    @(negedge clk);
    reset = 0;
    OSD_STATUS = 0;
    ref_bv = 0;
    ref_saved = '0;
    repeat (3) @(negedge clk);
    mem[7] = mem[7] ^ 8'hFF;
    osd_cycle(1);

    for (int k = 0; k < 8; k++) begin
      int r = $urandom_range(0, 3);
      int p = $urandom_range(0, 63);
      logic [7:0] old = mem[p];
      if (r != 0) mem[p] = 8'($urandom);
      if (r == 3) mem[p] = old;
      osd_cycle(r != 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
